// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers ALU commands in a FIFO, issues them one at a time to an
// external combinational ALU, captures each result and its flags, and returns them over
// a valid/ready response channel. cmd_chain replaces operand A with the previous result.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   cmd_valid/cmd_ready            command handshake (cmd_ready = FIFO not full)
//   cmd_a/cmd_b/cmd_op/cmd_dir     command payload
//   cmd_chain                      1: operand A taken from the accumulator
//   alu_a/alu_b/alu_op/alu_dir     registered operands to the ALU
//   alu_result/zero/carry/overflow ALU outputs
//   rsp_valid/rsp_ready            response handshake
//   rsp_result/zero/carry/overflow captured response
//   fifo_count                     queued commands (in-flight command excluded)
//   busy                           sequencer active or commands queued
module alu_cmd_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [WIDTH-1:0]         cmd_a,
  input  logic [WIDTH-1:0]         cmd_b,
  input  logic [2:0]               cmd_op,
  input  logic                     cmd_dir,
  input  logic                     cmd_chain,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [2:0]               alu_op,
  output logic                     alu_dir,
  input  logic [WIDTH-1:0]         alu_result,
  input  logic                     alu_zero,
  input  logic                     alu_carry,
  input  logic                     alu_overflow,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_zero,
  output logic                     rsp_carry,
  output logic                     rsp_overflow,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic             chain;
    logic             dir;
    logic [2:0]       op;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] a;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [WIDTH-1:0] acc;
  state_t        state;
  state_t        state_nxt;
  logic          fifo_empty;
  logic          push_c;
  logic          pop_c;
  logic          capture_c;
  logic          rsp_done_c;

  assign fifo_empty = (fifo_count == '0);
  assign cmd_ready  = (fifo_count != CW'(DEPTH));
  assign push_c     = cmd_valid & cmd_ready;
  assign head       = mem[rd_ptr];
  assign busy       = (state != IDLE) || !fifo_empty;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (!fifo_empty) state_nxt = EXEC;
      EXEC: state_nxt = HOLD;
      HOLD: if (rsp_valid && rsp_ready) state_nxt = fifo_empty ? IDLE : EXEC;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM strobes: pop the FIFO head, capture ALU output, retire a response
  always_comb begin
    pop_c      = 1'b0;
    capture_c  = 1'b0;
    rsp_done_c = 1'b0;
    unique case (state)
      IDLE: pop_c = !fifo_empty;
      EXEC: capture_c = 1'b1;
      HOLD: begin
        rsp_done_c = rsp_valid & rsp_ready;
        pop_c      = rsp_valid & rsp_ready & !fifo_empty;
      end
      default: ;
    endcase
  end

  // FIFO storage; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= '{chain: cmd_chain, dir: cmd_dir, op: cmd_op, b: cmd_b, a: cmd_a};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
      if (push_c && !pop_c)      fifo_count <= fifo_count + CW'(1);
      else if (pop_c && !push_c) fifo_count <= fifo_count - CW'(1);
    end
  end

  // Issue and capture datapath; pops only follow a capture, so acc is always current
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= '0;
      alu_dir      <= 1'b0;
      acc          <= '0;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
    end else begin
      if (pop_c) begin
        alu_a   <= head.chain ? acc : head.a;
        alu_b   <= head.b;
        alu_op  <= head.op;
        alu_dir <= head.dir;
      end
      if (capture_c) begin
        rsp_result   <= alu_result;
        rsp_zero     <= alu_zero;
        rsp_carry    <= alu_carry;
        rsp_overflow <= alu_overflow;
        acc          <= alu_result;
        rsp_valid    <= 1'b1;
      end else if (rsp_done_c) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
